lc3_mem_if: RTL and testbench
=============================

// Module: lc3_mem_if
// PURPOSE
//   MAR/MDR memory-interface unit of the LC-3 datapath. Loads MAR/MDR from the
//   shared tristate data_bus and drives MDR back onto it under gate_mdr.
//   Runs a req/ack handshake to external memory and returns the LC-3 R
//   (ready) signal to the control FSM.
// PARAMETERS
//   TIMEOUT_CYCLES  255  max cycles in REQ before abort (LC3_MEM_TIMEOUT_EN only)
// PORTS
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous reset, active-low
//   ld_mar     in   1   MAR <= data_bus
//   ld_mdr     in   1   MDR load (source set by mio_en)
//   mio_en     in   1   memory access requested / MDR source = memory
//   r_w        in   1   1 = write, 0 = read
//   gate_mdr   in   1   drive MDR onto data_bus
//   data_bus   inout 16 shared datapath bus
//   mem_r      out  1   ready to control FSM (LC-3 R)
//   mar        out  16  MAR contents
//   mdr        out  16  MDR contents
//   mem_req    out  1   memory request, held until ack
//   mem_we     out  1   write enable, valid with mem_req
//   mem_addr   out  16  address, valid with mem_req
//   mem_wdata  out  16  write data, valid with mem_req
//   mem_rdata  in   16  read data, sampled on mem_ack
//   mem_ack    in   1   single-cycle completion from memory
//   bus_err    out  1   sticky timeout flag (0 without LC3_MEM_TIMEOUT_EN)
// BEHAVIOUR
//   - Reset (rst=0, async): mar=0, mdr=0, rdata_q=0, state=IDLE, mem_req=0,
//     mem_we=0, mem_addr=0, mem_wdata=0, mem_r=0, bus_err=0.
//     Reset mid-access aborts it; mem_req falls immediately.
//   - data_bus = gate_mdr ? mdr : 16'hzzzz.
//   - ld_mar=1: mar <= data_bus on the next edge, in any state.
//   - ld_mdr=1, mio_en=0: mdr <= data_bus.
//   - ld_mdr=1, mio_en=1: mdr <= rdata_q only in DONE; otherwise mdr holds.
//   - ld_mar and ld_mdr (mio_en=0) together: both load the same bus value.
//   - FSM states:
//       IDLE -> REQ when mio_en=1. On that edge capture mem_addr<=mar,
//         mem_wdata<=mdr, mem_we<=r_w, and set mem_req<=1.
//       REQ: mem_req=1. Captured values stay stable; later MAR/MDR loads do
//         not affect them. On mem_ack=1: rdata_q<=mem_rdata (reads only),
//         mem_req<=0, go to DONE.
//       DONE: mem_r=1 for exactly one cycle, then IDLE. If mio_en is still 1
//         in IDLE, a new access starts.
//   - mem_ack outside REQ is ignored.
//   - Minimum latency: mio_en seen at edge 0; mem_req high after edge 0;
//     ack sampled at edge 1; mem_r high after edge 1. Total 2 cycles per access.
//   - mio_en dropping during REQ does not cancel the access.
//   - mem_r is combinational from state (state==DONE).
// CONFIGURATION
//   LC3_MEM_TIMEOUT_EN defined:
//     - An 8-bit-or-wider counter clears on REQ entry and increments each REQ
//       cycle.
//     - At count == TIMEOUT_CYCLES with no ack: mem_req<=0, rdata_q<=16'hFFFF,
//       bus_err<=1 (sticky until reset), go to DONE.
//     - Ack on the same edge as the timeout wins: normal completion, no error.
//   LC3_MEM_TIMEOUT_EN undefined:
//     - REQ waits indefinitely; no counter; bus_err tied to 0.
// TESTING
//   - Reset: rst=0 mid-REQ -> mem_req=0 immediately; mar=mdr=0; bus z with
//     gate_mdr=0.
//   - Read: bus=16'h3000, ld_mar; mio_en=1, r_w=0; ack after 3 cycles with
//     rdata=16'hBEEF -> mem_addr=3000 through REQ, mem_r one cycle, ld_mdr in
//     DONE -> mdr=BEEF; gate_mdr drives BEEF.
//   - Write: mar=3001, mdr=1234 from bus; mio_en=1, r_w=1, immediate ack ->
//     mem_we=1, wdata=1234, mem_r 2 cycles after mio_en.
//   - Stability: change mar to 4000 during REQ -> mem_addr stays 3000 until ack.
//   - Back-to-back: mio_en held high across two accesses -> two req/ack
//     cycles, two single-cycle mem_r pulses.
//   - LC3_MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4
//     REQ cycles, bus_err=1, mdr load yields FFFF.
//   - LC3_MEM_TIMEOUT_EN: ack on the timeout edge -> bus_err stays 0.

Source files
------------

// File: rtl/lc3_mem_if.sv
// LC-3 MAR/MDR memory interface: bus loads, MDR bus drive, req/ack handshake and the R signal.
// Optional REQ timeout with sticky bus_err when LC3_MEM_TIMEOUT_EN is defined.
module lc3_mem_if
  #(parameter int unsigned TIMEOUT_CYCLES = 255)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        gate_mdr,
  inout  wire  [15:0] data_bus,
  output logic        mem_r,
  output logic [15:0] mar,
  output logic [15:0] mdr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;

`ifdef LC3_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
`endif

  assign data_bus = gate_mdr ? mdr_q : 16'hzzzz;

  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LC3_MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = bus_err_q;
`endif

    if (ld_mar) mar_d = data_bus;

    // Memory-sourced MDR loads only take effect once the read data is ready.
    if (ld_mdr) begin
      if (!mio_en)              mdr_d = data_bus;
      else if (state_q == DONE) mdr_d = rdata_q;
    end

    case (state_q)
      IDLE: begin
        if (mio_en) begin
          state_d     = REQ;
          mem_addr_d  = mar_q;
          mem_wdata_d = mdr_q;
          mem_we_d    = r_w;
          mem_req_d   = 1'b1;
`ifdef LC3_MEM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (!mem_we_q) rdata_d = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end
`ifdef LC3_MEM_TIMEOUT_EN
        // The edge that would bring the count to TIMEOUT_CYCLES aborts the access.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          mem_req_d = 1'b0;
          rdata_d   = 16'hFFFF;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mar_q       <= '0;
      mdr_q       <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef LC3_MEM_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LC3_MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign mem_r     = (state_q == DONE);
  assign mar       = mar_q;
  assign mdr       = mdr_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
`ifdef LC3_MEM_TIMEOUT_EN
  assign bus_err   = bus_err_q;
`else
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_if.sv
// Bench for lc3_mem_if: directed cases plus randomized accesses against a transaction-level model.
module tb_lc3_mem_if;
  logic        clk = 1'b0;
  logic        rst;
  logic        ld_mar, ld_mdr, mio_en, r_w, gate_mdr, mem_ack;
  logic [15:0] mem_rdata;
  wire  [15:0] data_bus;
  logic        mem_r, mem_req, mem_we, bus_err;
  logic [15:0] mar, mdr, mem_addr, mem_wdata;

  logic        drv_en;
  logic [15:0] drv_val;
  assign data_bus = drv_en ? drv_val : 16'hzzzz;

  int checks = 0;
  int failures = 0;

  // Architectural view: register contents, last read data, sticky error.
  logic [15:0] m_mar, m_mdr, m_rdata;
  logic        m_err;

  always #5 clk = ~clk;

  lc3_mem_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en),
    .r_w(r_w), .gate_mdr(gate_mdr), .data_bus(data_bus), .mem_r(mem_r),
    .mar(mar), .mdr(mdr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .bus_err(bus_err)
  );

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v, input bit lmar, input bit lmdr);
    drv_en = 1'b1; drv_val = v; ld_mar = lmar; ld_mdr = lmdr; mio_en = 1'b0;
    step;
    ld_mar = 1'b0; ld_mdr = 1'b0; drv_en = 1'b0;
    if (lmar) m_mar = v;
    if (lmdr) m_mdr = v;
  endtask

  // One full access from IDLE: request, dly wait cycles, ack, then an MDR load in DONE.
  task automatic access(input logic rw, input int dly, input logic [15:0] rd, input bit mar_change);
    logic [15:0] cap_addr, cap_wdata;
    cap_addr  = m_mar;
    cap_wdata = m_mdr;
    mio_en = 1'b1; r_w = rw;
    step;
    mio_en = 1'b0; r_w = 1'($urandom);
    chk1 ("req_rise", mem_req, 1'b1);
    chk16("addr_cap", mem_addr, cap_addr);
    chk16("wdata_cap", mem_wdata, cap_wdata);
    chk1 ("we_cap", mem_we, rw);
    chk1 ("r_low_req", mem_r, 1'b0);
    for (int i = 0; i < dly; i++) begin
      if (mar_change) begin
        drv_en = 1'b1; drv_val = 16'h4000 + 16'(i); ld_mar = 1'b1;
      end
      step;
      if (mar_change) begin
        m_mar = drv_val; ld_mar = 1'b0; drv_en = 1'b0;
      end
      chk1 ("req_hold", mem_req, 1'b1);
      chk16("addr_stable", mem_addr, cap_addr);
      chk1 ("r_low_wait", mem_r, 1'b0);
    end
    mem_ack = 1'b1; mem_rdata = rd;
    step;
    mem_ack = 1'b0; mem_rdata = 16'($urandom);
    if (!rw) m_rdata = rd;
    chk1("req_fall", mem_req, 1'b0);
    chk1("r_pulse", mem_r, 1'b1);
    chk1("bus_err", bus_err, m_err);
    ld_mdr = 1'b1; mio_en = 1'b1;
    step;
    ld_mdr = 1'b0; mio_en = 1'b0;
    m_mdr = m_rdata;
    chk16("mdr_mem_load", mdr, m_mdr);
    chk1 ("r_one_cycle", mem_r, 1'b0);
    chk1 ("req_idle", mem_req, 1'b0);
    chk16("mar_after", mar, m_mar);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v, x;
    logic        exp_req [6];
    logic        exp_r   [6];
    int          pulses;

    rst = 1'b0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0; gate_mdr = 0;
    mem_ack = 0; mem_rdata = 16'h0; drv_en = 0; drv_val = 16'h0;
    m_mar = 0; m_mdr = 0; m_rdata = 0; m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    chk16("rst_mar", mar, 16'h0);
    chk16("rst_mdr", mdr, 16'h0);
    chk1 ("rst_req", mem_req, 1'b0);
    chk1 ("rst_we", mem_we, 1'b0);
    chk16("rst_addr", mem_addr, 16'h0);
    chk16("rst_wdata", mem_wdata, 16'h0);
    chk1 ("rst_r", mem_r, 1'b0);
    chk1 ("rst_err", bus_err, 1'b0);
    rst = 1'b1;
    step;

    // Read with stability check: MAR changes during REQ must not move mem_addr.
    load(16'h3000, 1, 0);
    chk16("mar_load", mar, 16'h3000);
    access(1'b0, 3, 16'hBEEF, 1);
    chk16("read_mdr", mdr, 16'hBEEF);
    gate_mdr = 1'b1;
    #1;
    chk16("gate_mdr_bus", data_bus, 16'hBEEF);
    gate_mdr = 1'b0;
    #1;

    // Write with immediate ack; rdata is untouched so DONE load still gives BEEF.
    load(16'h3001, 1, 0);
    load(16'h1234, 0, 1);
    chk16("mdr_bus_load", mdr, 16'h1234);
    access(1'b1, 0, 16'h5555, 0);

    // Ack outside REQ is ignored.
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step;
    mem_ack = 1'b0;
    chk1("stray_ack_req", mem_req, 1'b0);
    chk1("stray_ack_r", mem_r, 1'b0);
    load(16'h0777, 1, 0);
    access(1'b1, 1, 16'h0, 0);
    chk16("stray_ack_rdata", mdr, 16'hBEEF);

    // Simultaneous MAR/MDR load from the bus.
    load(16'hA55A, 1, 1);
    chk16("both_mar", mar, 16'hA55A);
    chk16("both_mdr", mdr, 16'hA55A);

    // Back-to-back with mio_en and ack held high.
    exp_req = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_r   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    x = 16'($urandom);
    mem_ack = 1'b1; mem_rdata = x; r_w = 1'b0; mio_en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      chk1("b2b_req", mem_req, exp_req[i]);
      chk1("b2b_r", mem_r, exp_r[i]);
      if (mem_r) pulses++;
    end
    mio_en = 1'b0; mem_ack = 1'b0;
    m_rdata = x;
    chk16("b2b_pulses", 16'(pulses), 16'd2);
    access(1'b1, 0, 16'h0, 0);
    chk16("b2b_rdata", mdr, x);

    // Randomized accesses against the model.
    for (int n = 0; n < 24; n++) begin
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 0) load(v, 1, 1);
      else begin
        load(v, 1, 0);
        load(16'($urandom), 0, 1);
      end
      access(1'($urandom), int'($urandom_range(0, 3)), 16'($urandom), bit'($urandom_range(0, 1)));
    end

`ifdef LC3_MEM_TIMEOUT_EN
    // Ack on the timeout edge completes normally.
    load(16'h2222, 1, 0);
    mio_en = 1'b1; r_w = 1'b0;
    step;
    mio_en = 1'b0;
    repeat (3) begin
      step;
      chk1("to_tie_req", mem_req, 1'b1);
    end
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    step;
    mem_ack = 1'b0;
    chk1("to_tie_r", mem_r, 1'b1);
    chk1("to_tie_err", bus_err, 1'b0);
    ld_mdr = 1'b1; mio_en = 1'b1;
    step;
    ld_mdr = 1'b0; mio_en = 1'b0;
    chk16("to_tie_mdr", mdr, 16'h1111);

    // No ack: abort after four REQ cycles.
    mio_en = 1'b1; r_w = 1'b0;
    step;
    mio_en = 1'b0;
    chk1("to_req0", mem_req, 1'b1);
    repeat (3) begin
      step;
      chk1("to_req_hold", mem_req, 1'b1);
    end
    step;
    m_err = 1'b1;
    chk1("to_req_drop", mem_req, 1'b0);
    chk1("to_r", mem_r, 1'b1);
    chk1("to_err", bus_err, 1'b1);
    ld_mdr = 1'b1; mio_en = 1'b1;
    step;
    ld_mdr = 1'b0; mio_en = 1'b0;
    chk16("to_mdr", mdr, 16'hFFFF);
    step;
    chk1("to_err_sticky", bus_err, 1'b1);
`endif

    // Reset in the middle of REQ.
    load(16'h3000, 1, 0);
    mio_en = 1'b1; r_w = 1'b0;
    step;
    mio_en = 1'b0;
    chk1("mid_req", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1 ("mid_rst_req", mem_req, 1'b0);
    chk16("mid_rst_mar", mar, 16'h0);
    chk16("mid_rst_mdr", mdr, 16'h0);
    chk1 ("mid_rst_r", mem_r, 1'b0);
    chk1 ("mid_rst_err", bus_err, 1'b0);
    drv_en = 1'b1; drv_val = 16'hA5A5;
    #1;
    chk16("bus_released", data_bus, 16'hA5A5);
    drv_en = 1'b0;
    step;
    rst = 1'b1;
    m_mar = 0; m_mdr = 0; m_rdata = 0; m_err = 0;
    step;
    access(1'b1, 0, 16'h0, 0);
    chk16("post_rst_rdata", mdr, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
